// File: rtl/clock_phase_pkg.sv
// rtl/clock_phase_pkg.sv - shared state encoding and phase-decode helpers for clock_phase_gen
package clock_phase_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } cpg_state_e;

  function automatic int unsigned quarter_phase(input int unsigned div);
    return div / 4;
  endfunction

  function automatic int unsigned half_phase(input int unsigned div);
    return div / 2;
  endfunction

  function automatic int unsigned three_quarter_phase(input int unsigned div);
    return (3 * div) / 4;
  endfunction

  // Derived clock levels for phase p, packed as {dmem, regfile, processor, imem}.
  // During the first period after (re)start dmem is held low over its leading
  // quarter so that no derived clock comes out of reset already high.
  function automatic logic [3:0] phase_decode(input int unsigned div,
                                              input int unsigned p,
                                              input logic        first_period);
    logic [3:0] clks;
    clks[0] = (p < half_phase(div));
    clks[1] = (p >= quarter_phase(div)) && (p < three_quarter_phase(div));
    clks[2] = (p >= half_phase(div));
    clks[3] = ((p < quarter_phase(div)) && !first_period) ||
              (p >= three_quarter_phase(div));
    return clks;
  endfunction

endpackage

// File: rtl/reset_stretch.sv
// rtl/reset_stretch.sv - stretches reset by RESET_HOLD cycles and flags the release edge
module reset_stretch #(
  parameter int RESET_HOLD = 4
) (
  input  logic clock_i,
  input  logic reset_i,
  output logic sys_reset_o,
  output logic release_o
);

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          sys_reset_q, sys_reset_d;
  logic          last_hold;

  assign last_hold = (hold_cnt_q == HW'(RESET_HOLD - 1));

  // Count held cycles while reset is stretched; drop sys_reset on the last one.
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    sys_reset_d = sys_reset_q;
    if (sys_reset_q) begin
      if (last_hold) begin
        sys_reset_d = 1'b0;
        hold_cnt_d  = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end
  end

  // Reset re-arms the stretch from zero regardless of where it was.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hold_cnt_q  <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      sys_reset_q <= sys_reset_d;
    end
  end

  assign sys_reset_o = sys_reset_q;
  assign release_o   = sys_reset_q && last_hold && !reset_i;

endmodule

// File: rtl/clock_phase_gen.sv
// rtl/clock_phase_gen.sv - four phase-staggered derived clocks with halt and stretched reset (option: CLOCK_PHASE_GEN_CYCLE_COUNT_EN)
module clock_phase_gen
  import clock_phase_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int RESET_HOLD = 4,
  parameter int CNT_W      = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic halt,
  output logic sys_reset,
  output logic imem_clock,
  output logic processor_clock,
  output logic regfile_clock,
  output logic dmem_clock,
  output logic halted
`ifdef CLOCK_PHASE_GEN_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] run_cycles
`endif
);

  localparam int PW = $clog2(DIV);

  cpg_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, phase_nxt;
  logic [3:0]    clks_q, clks_d;
  logic          halted_q, halted_d;
  logic          first_q, first_d;
  logic          wrap;
  logic          release_pulse;

  reset_stretch #(
    .RESET_HOLD(RESET_HOLD)
  ) u_reset_stretch (
    .clock_i    (clock),
    .reset_i    (reset),
    .sys_reset_o(sys_reset),
    .release_o  (release_pulse)
  );

  // Next-state logic; clock flops are loaded with the decode of the next phase.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    clks_d    = clks_q;
    halted_d  = halted_q;
    first_d   = first_q;
    phase_nxt = phase_q + PW'(1);
    wrap      = (state_q == RUN) && (phase_q == PW'(DIV - 1));
    case (state_q)
      HOLD: begin
        clks_d   = '0;
        halted_d = 1'b0;
        phase_d  = '0;
        if (release_pulse) begin
          state_d = RUN;
          first_d = 1'b1;
          clks_d  = phase_decode(DIV, 0, 1'b1);
        end
      end
      RUN: begin
        if (wrap && halt) begin
          state_d  = HALT;
          phase_d  = '0;
          clks_d   = '0;
          halted_d = 1'b1;
          first_d  = 1'b0;
        end else begin
          phase_d = phase_nxt;
          first_d = first_q && !wrap;
          clks_d  = phase_decode(DIV, 32'(phase_nxt), first_d);
        end
      end
      HALT: begin
        if (!halt) begin
          state_d  = RUN;
          phase_d  = '0;
          halted_d = 1'b0;
          first_d  = 1'b1;
          clks_d   = phase_decode(DIV, 0, 1'b1);
        end
      end
      default: begin
        state_d = HOLD;
        clks_d  = '0;
      end
    endcase
  end

  // State register; reset overrides every state including mid-halt.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= HOLD;
      phase_q  <= '0;
      clks_q   <= '0;
      halted_q <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      clks_q   <= clks_d;
      halted_q <= halted_d;
      first_q  <= first_d;
    end
  end

  assign imem_clock      = clks_q[0];
  assign processor_clock = clks_q[1];
  assign regfile_clock   = clks_q[2];
  assign dmem_clock      = clks_q[3];
  assign halted          = halted_q;

`ifdef CLOCK_PHASE_GEN_CYCLE_COUNT_EN
  logic [CNT_W-1:0] run_cycles_q;

  // Count completed derived periods; every wrap edge in RUN closes one.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_cycles_q <= '0;
    end else if (wrap) begin
      run_cycles_q <= run_cycles_q + CNT_W'(1);
    end
  end

  assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_clock_phase_gen.sv
// tb/tb_clock_phase_gen.sv - scoreboard bench for clock_phase_gen against a cycle-level reference model
module tb_clock_phase_gen;

  localparam int DIV        = 4;
  localparam int RESET_HOLD = 3;
  localparam int CNT_W      = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic halt  = 1'b0;
  logic sys_reset, imem_clock, processor_clock, regfile_clock, dmem_clock, halted;
`ifdef CLOCK_PHASE_GEN_CYCLE_COUNT_EN
  logic [CNT_W-1:0] run_cycles;
`endif

  clock_phase_gen #(
    .DIV       (DIV),
    .RESET_HOLD(RESET_HOLD),
    .CNT_W     (CNT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .halt           (halt),
    .sys_reset      (sys_reset),
    .imem_clock     (imem_clock),
    .processor_clock(processor_clock),
    .regfile_clock  (regfile_clock),
    .dmem_clock     (dmem_clock),
    .halted         (halted)
`ifdef CLOCK_PHASE_GEN_CYCLE_COUNT_EN
    ,
    .run_cycles     (run_cycles)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [5:0]  exp_q[$];
  int unsigned exp_cnt_q[$];

  // Reference model: mode 0 = holding reset, 1 = running, 2 = halted.
  // m_t counts edges since the current run segment started.
  int          m_mode = 0;
  int          m_hold = 0;
  int          m_t    = 0;
  int unsigned m_cnt  = 0;
  bit          started = 0;

  function automatic logic [5:0] model_out(input int mode, input int t);
    int   p;
    logic im, pr, rf, dm;
    p  = t % DIV;
    im = 1'b0; pr = 1'b0; rf = 1'b0; dm = 1'b0;
    if (mode == 1) begin
      im = (p < DIV / 2);
      pr = (p >= DIV / 4) && (p < 3 * DIV / 4);
      rf = (p >= DIV / 2);
      dm = ((p < DIV / 4) && (t >= DIV)) || (p >= 3 * DIV / 4);
    end
    return {mode == 0, im, pr, rf, dm, mode == 2};
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      cycle++;
      if (reset) begin
        started = 1;
        m_mode  = 0;
        m_hold  = 0;
        m_cnt   = 0;
      end else if (started) begin
        case (m_mode)
          0: begin
            m_hold++;
            if (m_hold == RESET_HOLD) begin
              m_mode = 1;
              m_t    = 0;
            end
          end
          1: begin
            if (m_t % DIV == DIV - 1) begin
              m_cnt = (m_cnt + 1) % (1 << CNT_W);
              if (halt) m_mode = 2;
              else m_t++;
            end else begin
              m_t++;
            end
          end
          default: begin
            if (!halt) begin
              m_mode = 1;
              m_t    = 0;
            end
          end
        endcase
      end
      if (started) begin
        exp_q.push_back(model_out(m_mode, m_t));
        exp_cnt_q.push_back(m_cnt);
      end
    end
  end

  initial begin
    logic [5:0]  act, exp;
    int unsigned exp_cnt;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp     = exp_q.pop_front();
        exp_cnt = exp_cnt_q.pop_front();
        act     = {sys_reset, imem_clock, processor_clock, regfile_clock, dmem_clock, halted};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL outputs cycle %0d got {rst,im,pr,rf,dm,hlt}=%b want %b", cycle, act, exp);
        end
`ifdef CLOCK_PHASE_GEN_CYCLE_COUNT_EN
        checks++;
        if (run_cycles !== CNT_W'(exp_cnt)) begin
          errors++;
          $display("FAIL run_cycles cycle %0d got %0d want %0d", cycle, run_cycles, exp_cnt);
        end
`endif
      end
    end
  end

  task automatic wait_phase(input int p, input string what);
    int n = 0;
    @(negedge clock);
    while (!(m_mode == 1 && m_t % DIV == p) && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for phase %0d", what, p);
    end
  endtask

  task automatic wait_mode(input int mode, input string what);
    int n = 0;
    while (m_mode != mode && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for mode %0d", what, mode);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    halt  = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;

    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (sys_reset && n < 10);
    checks++;
    if (n != RESET_HOLD) begin
      errors++;
      $display("FAIL release_latency got %0d edges want %0d", n, RESET_HOLD);
    end

    repeat (12) @(negedge clock);

    wait_phase(1, "halt_entry");
    halt = 1'b1;
    wait_mode(2, "halt_entry");
    repeat (2) @(negedge clock);
    halt = 1'b0;
    repeat (8) @(negedge clock);

    wait_phase(1, "short_pulse");
    halt = 1'b1;
    repeat (2) @(negedge clock);
    halt = 1'b0;
    repeat (8) @(negedge clock);

    wait_phase(2, "reset_run");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    halt = 1'b1;
    wait_mode(2, "reset_halt");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    halt  = 1'b0;

    repeat (18 * DIV + RESET_HOLD + 2) @(negedge clock);
    halt = 1'b1;
    repeat (9) @(negedge clock);
    halt = 1'b0;
    repeat (6) @(negedge clock);

    repeat (400) begin
      @(negedge clock);
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 5) == 0) halt = ~halt;
    end
    reset = 1'b0;
    halt  = 1'b0;
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/clock_phase_gen.md
Name: clock_phase_gen

Overview:
Receives the bench/board master `clock` and `reset` and produces the four phase-staggered clocks consumed by the skeleton: `imem_clock`, `processor_clock`, `regfile_clock` and `dmem_clock`. It also produces a stretched, synchronous system reset. A halt request freezes all derived clocks low on a clean period boundary. It sits at the top of the skeleton, between the clock/reset source and the processor, imem, dmem and regfile.

Parameters:
- DIV, 4: derived-clock period in master cycles. Power of 2, >= 4.
- RESET_HOLD, 4: master cycles `sys_reset` stays high after `reset` is sampled low. Must be >= 1.
- CNT_W, 32: width of the optional cycle counter.

Ports:
- clock  in  1  master clock; all flops on posedge.
- reset  in  1  synchronous, active-high reset.
- halt  in  1  request to freeze the derived clocks; level-sensitive.
- sys_reset  out  1  stretched synchronous reset to the downstream blocks.
- imem_clock  out  1  50% duty, period DIV, rises at phase 0.
- processor_clock  out  1  50% duty, period DIV, rises at phase DIV/4.
- regfile_clock  out  1  50% duty, period DIV, rises at phase DIV/2.
- dmem_clock  out  1  50% duty, period DIV, rises at phase 3*DIV/4.
- halted  out  1  high while in HALT.

Behaviour:
- Every output comes directly from a flop. No combinational gating of `clock`.
- State machine states: HOLD, RUN, HALT.
- Phase counter: log2(DIV) bits, advances only in RUN, wraps DIV-1 -> 0.
- Reset, taking priority in any state, mid-period or mid-halt: on the next edge go to HOLD with hold_cnt=0, phase=0, `sys_reset`=1, all four clocks=0, `halted`=0.
- HOLD, `reset` low: hold_cnt increments each edge.
  - On the edge where hold_cnt==RESET_HOLD-1: go to RUN with phase=0, `sys_reset`=0, `imem_clock`=1, other clocks 0.
  - Result: `sys_reset` falls exactly RESET_HOLD edges after `reset` is first sampled low.
- RUN: for a cycle whose phase register holds p (the output flops are loaded from the decode of the next phase):
  - `imem_clock` = (p < DIV/2).
  - `processor_clock` = (DIV/4 <= p < 3*DIV/4).
  - `regfile_clock` = (p >= DIV/2).
  - `dmem_clock` = (p < DIV/4) or (p >= 3*DIV/4).
  - Exception: in the first RUN period, `dmem_clock` is forced 0 for p < DIV/4, so no derived clock starts high.
- RUN to HALT: `halt` is acted on only at the wrap edge (phase DIV-1 -> 0). If `halt`=1 at that edge, go to HALT: all four clocks 0, phase=0, `halted`=1.
  - `halt` pulses that fall before a wrap edge are ignored.
- HALT to RUN: on the first edge with `halt`=0, go to RUN at phase 0, with the same first-period rule as after HOLD. `halted` clears on that edge.
- Reset and halt asserted together: reset wins.
- `sys_reset` is never asserted by halt.

Optional Feature:
- Macro: CLOCK_PHASE_GEN_CYCLE_COUNT_EN.
- Defined: adds output port `run_cycles` [CNT_W-1:0].
  - Cleared by `reset`.
  - Increments once per completed derived period, i.e. at each wrap edge in RUN.
  - Holds in HOLD and HALT. Wraps modulo 2^CNT_W.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package `clock_phase_pkg`:
  - state encoding typedef: HOLD=2'd0, RUN=2'd1, HALT=2'd2.
  - localparam functions for the quarter-phase boundaries, derived from DIV.
- One natural sub-module, `reset_stretch`: hold counter plus `sys_reset` flop, parameterised by RESET_HOLD, emitting a one-cycle `release` pulse that the FSM uses for HOLD->RUN.

Test Plan (DIV=4, RESET_HOLD=3 unless stated):
- Reset release: `reset`=1 for 5 cycles, then 0 -> `sys_reset` high through 2 more edges and low on the 3rd edge. On that edge `imem_clock`=1 and the other three clocks are 0.
- Steady RUN: observe 3 periods -> imem/processor/regfile/dmem each have period 4 and duty 2, rising at phases 0/1/2/3. `dmem_clock` is low during the first period's phase 0.
- Halt timing: `halt`=1 asserted at phase 1 -> clocks continue until the wrap edge, then all 0 and `halted`=1. Deassert `halt` -> next edge RUN at phase 0 with `imem_clock`=1.
- Short halt pulse: `halt` high only during phases 1-2 -> no HALT entry, clocks uninterrupted.
- Reset mid-operation: `reset`=1 at phase 2 while RUN, and again while HALT -> next edge all clocks 0, `sys_reset`=1, `halted`=0. Re-release follows the 3-edge rule.
- Counter (macro on, CNT_W=4): run 18 periods -> `run_cycles`=2 (wrapped). Unchanged across a HALT interval. 0 after reset.
